// File: rtl/uart_debug_cmd_if.sv
// UART byte streams and the one-word debug bus between the command parser and its neighbours.
interface uart_debug_cmd_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        uart_debug_req;
    logic        uart_debug_we;
    logic [31:0] uart_debug_addr;
    logic [31:0] uart_debug_wdata;
    logic        store_finish;
    logic        load_finish;
    logic [31:0] uart_debug_rdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, store_finish, load_finish, uart_debug_rdata,
        output rx_ready, tx_valid, tx_data, uart_debug_req, uart_debug_we,
               uart_debug_addr, uart_debug_wdata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, store_finish, load_finish, uart_debug_rdata,
        input  rx_ready, tx_valid, tx_data, uart_debug_req, uart_debug_we,
               uart_debug_addr, uart_debug_wdata
    );
endinterface

// File: rtl/uart_debug_cmd.sv
// Debug packet parser: decodes W/R/B packets from the UART, issues one-word
// store/load requests and answers with an ack, error or read-data bytes.
module uart_debug_cmd #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  ERR_BYTE       = 8'h45
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_debug_cmd_if.master bus,
    output logic             busy
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned TW = 32;

    localparam logic [BW-1:0] CMD_W = 8'h57;
    localparam logic [BW-1:0] CMD_R = 8'h52;
    localparam logic [BW-1:0] CMD_B = 8'h42;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_DATA,
        S_REQ,
        S_WAIT,
        S_TX
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   cmd_q, cmd_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-9:0]   tx_buf_q, tx_buf_d;
    logic [1:0]      tx_left_q, tx_left_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic            tx_valid_q, tx_valid_d;
    logic [BW-1:0]   tx_data_q, tx_data_d;
    logic            rx_ready_q, rx_ready_d;
    logic            busy_q, busy_d;

    logic            accept;
    logic            timed;

    assign accept = bus.rx_valid & rx_ready_q;
    assign timed  = (state_q == S_ADDR) || (state_q == S_CNT) || (state_q == S_DATA);

    // Next-state and datapath decode.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        tx_buf_d   = tx_buf_q;
        tx_left_d  = tx_left_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        we_d       = we_q;
        timer_d    = '0;
        if (timed && !accept) begin
            timer_d = timer_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    byte_cnt_d = '0;
                    if (bus.rx_data == CMD_W || bus.rx_data == CMD_R || bus.rx_data == CMD_B) begin
                        cmd_d   = bus.rx_data;
                        state_d = S_ADDR;
                    end else begin
                        tx_data_d  = ERR_BYTE;
                        tx_valid_d = 1'b1;
                        tx_left_d  = '0;
                        state_d    = S_TX;
                    end
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_d     = {bus.rx_data, addr_q[AW-1:BW]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (cmd_q == CMD_B) begin
                            state_d = S_CNT;
                        end else if (cmd_q == CMD_W) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_CNT: begin
                if (accept) begin
                    cnt_d      = {bus.rx_data, cnt_q[CW-1:BW]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd1) begin
                        byte_cnt_d = '0;
                        if (cnt_d == '0) begin
                            tx_data_d  = ACK_BYTE;
                            tx_valid_d = 1'b1;
                            tx_left_d  = '0;
                            state_d    = S_TX;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    data_d     = {bus.rx_data, data_q[DW-1:BW]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Only the finish pulse matching the outstanding request is honoured.
                if (cmd_q == CMD_R) begin
                    if (bus.load_finish) begin
                        tx_buf_d   = bus.uart_debug_rdata[DW-1:BW];
                        tx_data_d  = bus.uart_debug_rdata[BW-1:0];
                        tx_valid_d = 1'b1;
                        tx_left_d  = 2'd3;
                        state_d    = S_TX;
                    end
                end else if (bus.store_finish) begin
                    if (cmd_q == CMD_B) begin
                        addr_d = addr_q + 32'd4;
                        cnt_d  = cnt_q - 16'd1;
                    end
                    if (cmd_q == CMD_B && cnt_q != 16'd1) begin
                        byte_cnt_d = '0;
                        state_d    = S_DATA;
                    end else begin
                        tx_data_d  = ACK_BYTE;
                        tx_valid_d = 1'b1;
                        tx_left_d  = '0;
                        state_d    = S_TX;
                    end
                end
            end
            S_TX: begin
                if (bus.tx_ready) begin
                    if (tx_left_q == '0) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d = tx_buf_q[BW-1:0];
                        tx_buf_d  = {8'h00, tx_buf_q[DW-9:BW]};
                        tx_left_d = tx_left_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An unfinished packet that stalls too long is dropped silently.
        if (timed && !accept && timer_q >= TIMEOUT_CYCLES) begin
            state_d    = S_IDLE;
            byte_cnt_d = '0;
            cnt_d      = '0;
            timer_d    = '0;
        end

        req_d = (state_d == S_REQ);
        if (state_d == S_REQ) begin
            we_d = (cmd_q != CMD_R);
        end
        rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) ||
                     (state_d == S_CNT)  || (state_d == S_DATA);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            tx_buf_q   <= '0;
            tx_left_q  <= '0;
            timer_q    <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            tx_buf_q   <= tx_buf_d;
            tx_left_q  <= tx_left_d;
            timer_q    <= timer_d;
            req_q      <= req_d;
            we_q       <= we_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rx_ready         = rx_ready_q;
    assign bus.tx_valid         = tx_valid_q;
    assign bus.tx_data          = tx_data_q;
    assign bus.uart_debug_req   = req_q;
    assign bus.uart_debug_we    = we_q;
    assign bus.uart_debug_addr  = addr_q;
    assign bus.uart_debug_wdata = data_q;
    assign busy                 = busy_q;
endmodule
